// File: rtl/barrel_shift_arbiter_if.sv
// Requester, result and consumer signals
// shared by the shift arbiter and its users.
interface barrel_shift_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_shift;
  logic             req0_dir;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_shift;
  logic             req1_dir;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;

  modport master (
    output req0_valid, req0_data,
    output req0_shift, req0_dir,
    input  req0_ready,
    output req1_valid, req1_data,
    output req1_shift, req1_dir,
    input  req1_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req0_shift, req0_dir,
    output req0_ready,
    input  req1_valid, req1_data,
    input  req1_shift, req1_dir,
    output req1_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Two-requester arbiter sharing one
// logical barrel shifter, one result held.
module barrel_shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic clk,
  input logic rst,
  barrel_shift_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             oval_q, oval_d;
  logic [WIDTH-1:0] odat_q, odat_d;
  logic             oid_q, oid_d;

  logic             pick0, pick1;
  logic             rdy0, rdy1;
  logic [WIDTH-1:0] op_data;
  logic [SHW-1:0]   op_sh;
  logic             op_dir;
  logic [WIDTH-1:0] stg [SHW+1];

  // Grant: sole requester wins, on a tie the
  // one that was not granted last time wins.
  always_comb begin
    pick1 = bus.req1_valid &&
            (!bus.req0_valid || !last_q);
    pick0 = bus.req0_valid && !pick1;
    rdy0  = 1'b0;
    rdy1  = 1'b0;
    if (state_q == IDLE && !rst) begin
      rdy0 = pick0;
      rdy1 = pick1;
    end
  end

  // Operand mux and log-stage barrel shifter.
  always_comb begin
    op_data = pick1 ? bus.req1_data
                    : bus.req0_data;
    op_sh   = pick1 ? bus.req1_shift
                    : bus.req0_shift;
    op_dir  = pick1 ? bus.req1_dir
                    : bus.req0_dir;
    stg[0]  = op_data;
    for (int i = 0; i < SHW; i++) begin
      if (!op_sh[i])
        stg[i+1] = stg[i];
      else if (op_dir)
        stg[i+1] = stg[i] >> (1 << i);
      else
        stg[i+1] = stg[i] << (1 << i);
    end
  end

  // Next state: capture on acceptance,
  // release on the output handshake.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    oval_d  = oval_q;
    odat_d  = odat_q;
    oid_d   = oid_q;
    unique case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          state_d = HOLD;
          oval_d  = 1'b1;
          odat_d  = stg[SHW];
          oid_d   = rdy1;
          last_d  = rdy1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          oval_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      oval_q  <= 1'b0;
      odat_q  <= '0;
      oid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      oval_q  <= oval_d;
      odat_q  <= odat_d;
      oid_q   <= oid_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.out_valid  = oval_q;
  assign bus.out_data   = odat_q;
  assign bus.out_id     = oid_q;

endmodule
